// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Each frame packs four {dp, hex[3:0]} digits, digit0 in the low bits.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW0 = 2'd1,
      SHOW1 = 2'd2
   } state_t;

   localparam int FRAME_W = 20;
   localparam int DIGIT_W = 5;

   localparam logic [FRAME_W-1:0] IDLE_FRAME = 20'h0_0000;

   // One-hot owner indication for a given arbiter state.
   function automatic logic [1:0] grant_of(input state_t s);
      logic [1:0] g;
      g = 2'b00;
      case (s)
         SHOW0:   g = 2'b01;
         SHOW1:   g = 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Request/frame/grant bundle between the two display requesters and the arbiter.
// The master side is the requester pair; the slave side is the arbiter.
interface display_arbiter_if;
   import display_pkg::*;

   logic [1:0]         req_i;
   logic [FRAME_W-1:0] frame0_i;
   logic [FRAME_W-1:0] frame1_i;
   logic [1:0]         grant_o;
   logic [DIGIT_W-1:0] in0_o;
   logic [DIGIT_W-1:0] in1_o;
   logic [DIGIT_W-1:0] in2_o;
   logic [DIGIT_W-1:0] in3_o;

   modport master (
      output req_i, frame0_i, frame1_i,
      input  grant_o, in0_o, in1_o, in2_o, in3_o
   );

   modport slave (
      input  req_i, frame0_i, frame1_i,
      output grant_o, in0_o, in1_o, in2_o, in3_o
   );

endinterface

// File: rtl/hold_timer.sv
// Saturating ownership timer: counts cycles since the current grant started
// and flags when the minimum hold time has been served.
module hold_timer #(
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Clear wins over count so a back-to-back owner switch restarts from zero.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
         cnt <= '0;
      end else if (en && (cnt != LAST_CNT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign done = (cnt == LAST_CNT);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the four-digit display with a minimum hold time;
// registers the owner's frame and drives the scan driver digit inputs.
module display_arbiter
   import display_pkg::*;
#(
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   display_arbiter_if.slave  bus
);

   state_t             state, state_n;
   logic               last, last_n;
   logic [FRAME_W-1:0] frame_p0, frame_n;
   logic [1:0]         grant_p0;
   logic               hold_clr;
   logic               hold_en;
   logic               hold_done;

   hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (hold_clr),
      .en    (hold_en),
      .done  (hold_done)
   );

   assign hold_en = (state != IDLE);

   // last = 1 means requester 1 was served most recently, so requester 0
   // wins the first simultaneous request after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         last     <= 1'b1;
         frame_p0 <= IDLE_FRAME;
         grant_p0 <= 2'b00;
      end else begin
         state    <= state_n;
         last     <= last_n;
         frame_p0 <= frame_n;
         grant_p0 <= grant_of(state_n);
      end
   end

   always_comb begin
      state_n  = state;
      last_n   = last;
      frame_n  = frame_p0;
      hold_clr = 1'b0;
      unique case (state)
         IDLE: begin
            if ((bus.req_i == 2'b01) || ((bus.req_i == 2'b11) && last)) begin
               state_n  = SHOW0;
               frame_n  = bus.frame0_i;
               hold_clr = 1'b1;
            end else if ((bus.req_i == 2'b10) || ((bus.req_i == 2'b11) && !last)) begin
               state_n  = SHOW1;
               frame_n  = bus.frame1_i;
               hold_clr = 1'b1;
            end
         end
         SHOW0: begin
            if (hold_done && bus.req_i[1]) begin
               state_n  = SHOW1;
               last_n   = 1'b0;
               frame_n  = bus.frame1_i;
               hold_clr = 1'b1;
            end else if (bus.req_i[0]) begin
               frame_n = bus.frame0_i;
            end else if (hold_done) begin
               state_n = IDLE;
               last_n  = 1'b0;
               frame_n = IDLE_FRAME;
            end
         end
         SHOW1: begin
            // Mirror of SHOW0; a dropped request freezes the frame until hold expires.
            if (hold_done && bus.req_i[0]) begin
               state_n  = SHOW0;
               last_n   = 1'b1;
               frame_n  = bus.frame0_i;
               hold_clr = 1'b1;
            end else if (bus.req_i[1]) begin
               frame_n = bus.frame1_i;
            end else if (hold_done) begin
               state_n = IDLE;
               last_n  = 1'b1;
               frame_n = IDLE_FRAME;
            end
         end
         default: begin
            state_n = IDLE;
            frame_n = IDLE_FRAME;
         end
      endcase
   end

   assign bus.grant_o = grant_p0;
   assign bus.in0_o   = frame_p0[4:0];
   assign bus.in1_o   = frame_p0[9:5];
   assign bus.in2_o   = frame_p0[14:10];
   assign bus.in3_o   = frame_p0[19:15];

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with HOLD_CYCLES = 4: table of per-cycle vectors
// checked through an expectation queue, plus hand-written hold/switch sequences.
module tb_display_arbiter;
   import display_pkg::*;

   localparam int HOLD = 4;

   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic [19:0] f0;
      logic [19:0] f1;
      logic [1:0]  eg;
      logic [19:0] ef;
   } vec_t;

   typedef struct packed {
      logic [1:0]  g;
      logic [19:0] f;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   vec_t vecs[$];
   exp_t sb[$];

   display_arbiter_if bus ();

   display_arbiter #(
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [1:0] q, input logic [19:0] a,
                      input logic [19:0] b, input logic [1:0] g, input logic [19:0] f);
      vec_t v;
      v.rst = r; v.req = q; v.f0 = a; v.f1 = b; v.eg = g; v.ef = f;
      vecs.push_back(v);
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check({tag, "_grant"}, 32'(bus.grant_o), 32'(e.g));
      check({tag, "_in0"}, 32'(bus.in0_o), 32'(e.f[4:0]));
      check({tag, "_in1"}, 32'(bus.in1_o), 32'(e.f[9:5]));
      check({tag, "_in2"}, 32'(bus.in2_o), 32'(e.f[14:10]));
      check({tag, "_in3"}, 32'(bus.in3_o), 32'(e.f[19:15]));
   endtask

   initial begin
      exp_t e;
      int   cnt;

      bus.req_i    = 2'b00;
      bus.frame0_i = '0;
      bus.frame1_i = '0;

      // Reset, then idle with no requests.
      add(1, 2'b00, 20'h0, 20'h0, 2'b00, 20'h0);
      add(0, 2'b00, 20'h0, 20'h0, 2'b00, 20'h0);
      add(0, 2'b00, 20'hFFFFF, 20'hFFFFF, 2'b00, 20'h0);
      // Requester 0 alone, live frame update, then release after hold.
      add(0, 2'b01, 20'h43210, 20'h0, 2'b01, 20'h43210);
      add(0, 2'b01, 20'h43210, 20'h0, 2'b01, 20'h43210);
      add(0, 2'b01, 20'h43210, 20'h0, 2'b01, 20'h43210);
      add(0, 2'b01, 20'h87654, 20'h0, 2'b01, 20'h87654);
      add(0, 2'b00, 20'h87654, 20'h0, 2'b00, 20'h0);
      add(0, 2'b00, 20'h0, 20'h0, 2'b00, 20'h0);
      // Both requesting after reset: alternate every HOLD cycles, requester 0 first.
      add(1, 2'b00, 20'h0, 20'h0, 2'b00, 20'h0);
      for (int i = 0; i < 4; i++) add(0, 2'b11, 20'h11111, 20'h22222, 2'b01, 20'h11111);
      for (int i = 0; i < 4; i++) add(0, 2'b11, 20'h11111, 20'h22222, 2'b10, 20'h22222);
      for (int i = 0; i < 4; i++) add(0, 2'b11, 20'h11111, 20'h22222, 2'b01, 20'h11111);
      add(0, 2'b11, 20'h11111, 20'h22222, 2'b10, 20'h22222);
      // Requester 0 drops after one cycle: frame frozen until hold expires.
      add(1, 2'b00, 20'h0, 20'h0, 2'b00, 20'h0);
      add(0, 2'b01, 20'h12345, 20'h0, 2'b01, 20'h12345);
      add(0, 2'b00, 20'h0F0F0, 20'h0, 2'b01, 20'h12345);
      add(0, 2'b00, 20'h0F0F0, 20'h0, 2'b01, 20'h12345);
      add(0, 2'b00, 20'h0F0F0, 20'h0, 2'b01, 20'h12345);
      add(0, 2'b00, 20'h0F0F0, 20'h0, 2'b00, 20'h0);
      // Requester 1 holds for 10 cycles without a competitor.
      for (int i = 0; i < 5; i++) add(0, 2'b10, 20'hFFFFF, 20'h98765, 2'b10, 20'h98765);
      for (int i = 0; i < 5; i++) add(0, 2'b10, 20'hFFFFF, 20'h56789, 2'b10, 20'h56789);
      // Reset while requester 1 owns; the pointer must return to favour requester 0.
      add(1, 2'b10, 20'hFFFFF, 20'h56789, 2'b00, 20'h0);
      add(0, 2'b11, 20'h31415, 20'h27182, 2'b01, 20'h31415);
      add(0, 2'b11, 20'h31415, 20'h27182, 2'b01, 20'h31415);

      foreach (vecs[i]) begin
         rst          = vecs[i].rst;
         bus.req_i    = vecs[i].req;
         bus.frame0_i = vecs[i].f0;
         bus.frame1_i = vecs[i].f1;
         sb.push_back('{g: vecs[i].eg, f: vecs[i].ef});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check_outputs($sformatf("vec%0d", i), e);
      end

      // Exact hold length and gap-free switching, measured with bounded loops.
      rst = 1'b1;
      bus.req_i = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req_i    = 2'b11;
      bus.frame0_i = 20'hA0A0A;
      bus.frame1_i = 20'h05050;
      @(posedge clk);
      #1;
      cnt = 0;
      while ((bus.grant_o == 2'b01) && (cnt < 20)) begin
         cnt++;
         @(posedge clk);
         #1;
      end
      check("hold_len_r0", 32'(cnt), 32'(HOLD));
      check("switch_to_r1", 32'(bus.grant_o), 32'(2'b10));
      check_outputs("r1_frame", '{g: 2'b10, f: 20'h05050});
      cnt = 0;
      while ((bus.grant_o == 2'b10) && (cnt < 20)) begin
         cnt++;
         @(posedge clk);
         #1;
      end
      check("hold_len_r1", 32'(cnt), 32'(HOLD));
      check("switch_to_r0", 32'(bus.grant_o), 32'(2'b01));

      // Owner drops early, competitor arrives during the hold: no early preemption.
      bus.req_i = 2'b10;
      for (int i = 0; i < HOLD - 1; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("no_preempt%0d", i), 32'(bus.grant_o), 32'(2'b01));
      end
      @(posedge clk);
      #1;
      check("preempt_after_hold", 32'(bus.grant_o), 32'(2'b10));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
